// File: rtl/uart_receiver.sv
// 8N1-style UART receiver: oversamples a two-flop-synchronised line on an external tick,
// confirms the start bit at mid-bit, samples data mid-bit LSB first and checks the stop bit.
module uart_receiver #(
    parameter int p_OVERSAMPLE = 16,
    parameter int p_DATA_BITS  = 8
) (
    input  logic                   i_CLK,
    input  logic                   i_RESET,
    input  logic                   i_SAMPLE_EN,
    input  logic                   i_RX,
    output logic [p_DATA_BITS-1:0] o_DATA,
    output logic                   o_DATA_VALID,
    output logic                   o_FRAME_ERR,
    output logic                   o_RX_BUSY
);

    localparam int SCW = $clog2(p_OVERSAMPLE);
    localparam int BCW = $clog2(p_DATA_BITS) + 1;

    localparam logic [SCW-1:0] c_HALF_LAST = SCW'(p_OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] c_FULL_LAST = SCW'(p_OVERSAMPLE - 1);
    localparam logic [BCW-1:0] c_LAST_BIT  = BCW'(p_DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic                   rx_meta_q;
    logic                   rx_sync_q;
    state_t                 state_q,   state_d;
    logic [SCW-1:0]         smp_cnt_q, smp_cnt_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [p_DATA_BITS-1:0] shift_q,   shift_d;
    logic [p_DATA_BITS-1:0] data_q,    data_d;
    logic                   valid_q,   valid_d;
    logic                   ferr_q,    ferr_d;

    // Two-flop synchroniser on the asynchronous line, free-running on every clock
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Next-state logic; state and counters only move on sample ticks
    always_comb begin
        state_d   = state_q;
        smp_cnt_d = smp_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        if (i_SAMPLE_EN) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_sync_q) begin
                        smp_cnt_d = {SCW{1'b0}};
                        state_d   = S_START;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end
                S_START: begin
                    if (smp_cnt_q == c_HALF_LAST) begin
                        if (rx_sync_q) begin
                            state_d   = S_IDLE;
                        end else begin
                            smp_cnt_d = {SCW{1'b0}};
                            bit_cnt_d = {BCW{1'b0}};
                            state_d   = S_DATA;
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + SCW'(1);
                    end
                end
                S_DATA: begin
                    if (smp_cnt_q == c_FULL_LAST) begin
                        shift_d   = {rx_sync_q, shift_q[p_DATA_BITS-1:1]};
                        smp_cnt_d = {SCW{1'b0}};
                        if (bit_cnt_q == c_LAST_BIT) begin
                            state_d   = S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BCW'(1);
                        end
                    end else begin
                        smp_cnt_d = smp_cnt_q + SCW'(1);
                    end
                end
                S_STOP: begin
                    if (smp_cnt_q == c_FULL_LAST) begin
                        if (rx_sync_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ferr_d  = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        smp_cnt_d = smp_cnt_q + SCW'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, counter, shift and output registers
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q   <= S_IDLE;
            smp_cnt_q <= {SCW{1'b0}};
            bit_cnt_q <= {BCW{1'b0}};
            shift_q   <= {p_DATA_BITS{1'b0}};
            data_q    <= {p_DATA_BITS{1'b0}};
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_cnt_q <= smp_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
        end
    end

    assign o_DATA       = data_q;
    assign o_DATA_VALID = valid_q;
    assign o_FRAME_ERR  = ferr_q;
    assign o_RX_BUSY    = (state_q != S_IDLE);

endmodule
